// File: rtl/c1_bus_responder_pkg.sv
// cache_bus_pkg: shared definitions for the C1/A1/D1 CPU-to-cache bus.
// Holds the bus widths, the C1 command codes, the responder state type
// and the flat request payload handed to the cache core.
package cache_bus_pkg;

   localparam int unsigned TAG_W  = 10;
   localparam int unsigned SET_W  = 5;
   localparam int unsigned OFF_W  = 4;
   localparam int unsigned ADDR_W = TAG_W + SET_W + OFF_W;   // 19
   localparam int unsigned A1_W   = TAG_W + SET_W;           // 15
   localparam int unsigned D1_W   = 16;
   localparam int unsigned C1_W   = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [C1_W-1:0] C1_NOP             = 3'd0;
   localparam logic [C1_W-1:0] C1_READ8           = 3'd1;
   localparam logic [C1_W-1:0] C1_READ16          = 3'd2;
   localparam logic [C1_W-1:0] C1_READ32          = 3'd3;
   localparam logic [C1_W-1:0] C1_INVALIDATE_LINE = 3'd4;
   localparam logic [C1_W-1:0] C1_WRITE8          = 3'd5;
   localparam logic [C1_W-1:0] C1_WRITE16         = 3'd6;
   localparam logic [C1_W-1:0] C1_WRITE32         = 3'd7;
   localparam logic [C1_W-1:0] C1_RESPONSE        = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR2     = 3'd1,
      ST_DATA2     = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_CORE = 3'd4,
      ST_TURN      = 3'd5,
      ST_RESP1     = 3'd6,
      ST_RESP2     = 3'd7
   } state_e;

   typedef struct packed {
      logic [C1_W-1:0]   cmd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } c1_req_t;

   function automatic logic is_read(input logic [C1_W-1:0] cmd);
      return (cmd >= C1_READ8) && (cmd <= C1_READ32);
   endfunction

   function automatic logic is_write(input logic [C1_W-1:0] cmd);
      return cmd >= C1_WRITE8;
   endfunction

endpackage

// File: rtl/c1_bus_responder.sv
// c1_bus_responder: cache-side responder on the C1/A1/D1 bus.
// Collects a multi-cycle CPU command (command+tag/set, offset/data, optional
// upper data) into one request for the cache core, waits for the core
// completion, then returns a NOP completion (writes/invalidate) or RESPONSE
// plus read data on C1/D1 after a one-cycle turnaround.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   c1_in/out/oe       C1 command bus, split tri-state
//   a1_in              A1 address bus (input only)
//   d1_in/out/oe       D1 data bus, split tri-state
//   req_*              request to the cache core (valid/ready)
//   resp_valid/rdata   single-cycle completion from the core
// Optional: define C1_RESP_STATS_EN to add stat_reads/stat_writes/stat_inval
// counters of accepted requests per class.
module c1_bus_responder
   import cache_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [C1_W-1:0]   c1_in,
   output logic [C1_W-1:0]   c1_out,
   output logic              c1_oe,
   input  logic [A1_W-1:0]   a1_in,
   input  logic [D1_W-1:0]   d1_in,
   output logic [D1_W-1:0]   d1_out,
   output logic              d1_oe,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [C1_W-1:0]   req_cmd,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              resp_valid,
   input  logic [DATA_W-1:0] resp_rdata
`ifdef C1_RESP_STATS_EN
   ,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_inval
`endif
);

   state_e            state_q, state_d;
   c1_req_t           req_q, req_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              req_valid_d;
   logic              c1_oe_d, d1_oe_d;
   logic [C1_W-1:0]   c1_out_d;
   logic [D1_W-1:0]   d1_out_d;

   assign req_cmd   = req_q.cmd;
   assign req_addr  = req_q.addr;
   assign req_wdata = req_q.wdata;

   // State, request payload and registered bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         rdata_q   <= '0;
         req_valid <= 1'b0;
         c1_oe     <= 1'b0;
         d1_oe     <= 1'b0;
         c1_out    <= C1_NOP;
         d1_out    <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         rdata_q   <= rdata_d;
         req_valid <= req_valid_d;
         c1_oe     <= c1_oe_d;
         d1_oe     <= d1_oe_d;
         c1_out    <= c1_out_d;
         d1_out    <= d1_out_d;
      end
   end

   // Next state plus next values of every registered output; bus drive is
   // decided one state ahead so it is visible exactly in RESP1/RESP2.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      rdata_d     = rdata_q;
      req_valid_d = 1'b0;
      c1_oe_d     = 1'b0;
      d1_oe_d     = 1'b0;
      c1_out_d    = C1_NOP;
      d1_out_d    = '0;

      case (state_q)
         ST_IDLE: begin
            if (c1_in != C1_NOP) begin
               req_d.cmd   = c1_in;
               req_d.addr  = {a1_in, OFF_W'(0)};
               req_d.wdata = '0;
               state_d     = ST_ADDR2;
            end
         end

         ST_ADDR2: begin
            req_d.addr[OFF_W-1:0] = a1_in[OFF_W-1:0];
            if (req_q.cmd == C1_WRITE8) begin
               req_d.wdata = DATA_W'(d1_in[7:0]);
            end else if ((req_q.cmd == C1_WRITE16) || (req_q.cmd == C1_WRITE32)) begin
               req_d.wdata[D1_W-1:0] = d1_in;
            end
            if (req_q.cmd == C1_WRITE32) begin
               state_d = ST_DATA2;
            end else begin
               state_d     = ST_ISSUE;
               req_valid_d = 1'b1;
            end
         end

         ST_DATA2: begin
            req_d.wdata[DATA_W-1:D1_W] = d1_in;
            state_d     = ST_ISSUE;
            req_valid_d = 1'b1;
         end

         ST_ISSUE: begin
            if (req_ready) begin
               state_d = ST_WAIT_CORE;
            end else begin
               req_valid_d = 1'b1;
            end
         end

         ST_WAIT_CORE: begin
            if (resp_valid) begin
               rdata_d = resp_rdata;
               state_d = ST_TURN;
            end
         end

         ST_TURN: begin
            state_d = ST_RESP1;
            c1_oe_d = 1'b1;
            if (is_read(req_q.cmd)) begin
               c1_out_d = C1_RESPONSE;
               d1_oe_d  = 1'b1;
               d1_out_d = (req_q.cmd == C1_READ8) ? {8'h00, rdata_q[7:0]}
                                                  : rdata_q[D1_W-1:0];
            end
         end

         ST_RESP1: begin
            if (req_q.cmd == C1_READ32) begin
               state_d  = ST_RESP2;
               c1_oe_d  = 1'b1;
               d1_oe_d  = 1'b1;
               c1_out_d = C1_RESPONSE;
               d1_out_d = rdata_q[DATA_W-1:D1_W];
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RESP2: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

`ifdef C1_RESP_STATS_EN
   logic req_accept;
   assign req_accept = req_valid && req_ready;

   // Per-class counts of requests accepted by the core; wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_inval  <= '0;
      end else if (req_accept) begin
         if (is_read(req_q.cmd)) begin
            stat_reads <= stat_reads + 32'd1;
         end else if (is_write(req_q.cmd)) begin
            stat_writes <= stat_writes + 32'd1;
         end else begin
            stat_inval <= stat_inval + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_c1_bus_responder.sv
// Testbench for c1_bus_responder: directed transactions, a per-cycle
// expectation schedule built from the bus rules, and literal spot checks.
module tb_c1_bus_responder;
   import cache_bus_pkg::*;

   localparam int unsigned NCYC = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  c1_in, c1_out;
   logic        c1_oe, d1_oe;
   logic [14:0] a1_in;
   logic [15:0] d1_in, d1_out;
   logic        req_valid, req_ready;
   logic [2:0]  req_cmd;
   logic [18:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
`ifdef C1_RESP_STATS_EN
   logic [31:0] stat_reads, stat_writes, stat_inval;
`endif

   always #5 clk = ~clk;

   c1_bus_responder dut (
      .clk(clk), .reset(reset),
      .c1_in(c1_in), .c1_out(c1_out), .c1_oe(c1_oe),
      .a1_in(a1_in),
      .d1_in(d1_in), .d1_out(d1_out), .d1_oe(d1_oe),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef C1_RESP_STATS_EN
      , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_inval(stat_inval)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Expected outputs per cycle (cycle n = after the n-th rising edge).
   bit          exp_rv   [NCYC];
   bit          exp_c1oe [NCYC];
   bit          exp_d1oe [NCYC];
   logic [2:0]  exp_c1   [NCYC];
   logic [15:0] exp_d1   [NCYC];
   logic [2:0]  exp_cmd;
   logic [18:0] exp_addr;
   logic [31:0] exp_wdata;

   // Observations for the literal checks.
   logic [18:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [2:0]  cap_c1 [$];
   logic [15:0] cap_d1 [$];
   int          cap_rv;
   int          first_oe_cyc;

   int m_reads = 0, m_writes = 0, m_inval = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the schedule.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < NCYC) begin
         check("req_valid", 32'(req_valid), 32'(exp_rv[cyc]));
         check("c1_oe", 32'(c1_oe), 32'(exp_c1oe[cyc]));
         check("d1_oe", 32'(d1_oe), 32'(exp_d1oe[cyc]));
         if (exp_rv[cyc]) begin
            check("req_cmd", 32'(req_cmd), 32'(exp_cmd));
            check("req_addr", 32'(req_addr), 32'(exp_addr));
            check("req_wdata", req_wdata, exp_wdata);
         end
         if (exp_c1oe[cyc]) check("c1_out", 32'(c1_out), 32'(exp_c1[cyc]));
         if (exp_d1oe[cyc]) check("d1_out", 32'(d1_out), 32'(exp_d1[cyc]));
         if (req_valid) begin
            cap_addr  = req_addr;
            cap_wdata = req_wdata;
            cap_rv++;
         end
         if (c1_oe) begin
            cap_c1.push_back(c1_out);
            if (first_oe_cyc < 0) first_oe_cyc = cyc;
         end
         if (d1_oe) cap_d1.push_back(d1_out);
      end
   end

   task automatic clear_caps();
      cap_c1.delete();
      cap_d1.delete();
      cap_rv = 0;
      first_oe_cyc = -1;
   endtask

   // One full bus transaction with a cooperative core; schedules expectations.
   task automatic txn(input logic [2:0] cmd, input logic [14:0] ahi, input logic [3:0] off,
                      input logic [15:0] dlo, input logic [15:0] dhi, input int stall,
                      input int core_wait, input logic [31:0] rdata, input bit spur,
                      output int k0);
      int first, acc, r;
      clear_caps();
      @(negedge clk);
      c1_in = cmd;
      a1_in = ahi;
      k0 = cyc + 1;
      exp_cmd  = cmd;
      exp_addr = {ahi, off};
      case (cmd)
         C1_WRITE8:  exp_wdata = {24'h0, dlo[7:0]};
         C1_WRITE16: exp_wdata = {16'h0, dlo};
         C1_WRITE32: exp_wdata = {dhi, dlo};
         default:    exp_wdata = 32'h0;
      endcase
      first = k0 + 1 + ((cmd == C1_WRITE32) ? 1 : 0);
      for (int i = 0; i <= stall; i++) exp_rv[first + i] = 1'b1;
      acc = first + stall + 1;
      r   = acc + 1 + core_wait;
      exp_c1oe[r + 1] = 1'b1;
      if (cmd >= C1_READ8 && cmd <= C1_READ32) begin
         exp_c1[r + 1]   = C1_RESPONSE;
         exp_d1oe[r + 1] = 1'b1;
         exp_d1[r + 1]   = (cmd == C1_READ8) ? {8'h00, rdata[7:0]} : rdata[15:0];
         if (cmd == C1_READ32) begin
            exp_c1oe[r + 2] = 1'b1;
            exp_d1oe[r + 2] = 1'b1;
            exp_c1[r + 2]   = C1_RESPONSE;
            exp_d1[r + 2]   = rdata[31:16];
         end
      end else begin
         exp_c1[r + 1] = C1_NOP;
      end
      @(negedge clk);
      c1_in = C1_NOP;
      a1_in = {11'h0, off};
      d1_in = dlo;
      if (cmd == C1_WRITE32) begin
         @(negedge clk);
         d1_in = dhi;
      end
      while (cyc < acc - 1) @(negedge clk);
      d1_in = 16'h0;
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      if (cmd >= C1_READ8 && cmd <= C1_READ32) m_reads++;
      else if (cmd == C1_INVALIDATE_LINE) m_inval++;
      else m_writes++;
      if (spur) c1_in = C1_READ32;
      while (cyc < r - 1) @(negedge clk);
      resp_valid = 1'b1;
      resp_rdata = rdata;
      @(negedge clk);
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      c1_in = C1_NOP;
      while (cyc < r + 3) @(negedge clk);
   endtask

   initial begin
      int k0;
      reset = 1'b1;
      c1_in = C1_NOP;
      a1_in = '0;
      d1_in = '0;
      req_ready = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      clear_caps();
      repeat (3) @(negedge clk);
      check("rst_c1_out", 32'(c1_out), 32'h0);
      check("rst_d1_out", 32'(d1_out), 32'h0);
      check("rst_req_cmd", 32'(req_cmd), 32'h0);
      check("rst_req_addr", 32'(req_addr), 32'h0);
      check("rst_req_wdata", req_wdata, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // WRITE8, zero-wait core
      txn(C1_WRITE8, 15'd1337, 4'd8, 16'd228, 16'h0, 0, 0, 32'h0, 1'b0, k0);
      check("w8_addr", 32'(cap_addr), 32'd21400);
      check("w8_wdata", cap_wdata, 32'd228);
      check("w8_latency", 32'(first_oe_cyc - (k0 - 1)), 32'd5);
      check("w8_beats", 32'(cap_c1.size()), 32'd1);
      check("w8_d1_beats", 32'(cap_d1.size()), 32'd0);
      if (cap_c1.size() > 0) check("w8_c1", 32'(cap_c1[0]), 32'd0);

      // READ8 same address
      txn(C1_READ8, 15'd1337, 4'd8, 16'h0, 16'h0, 0, 0, 32'h123456E4, 1'b0, k0);
      check("r8_latency", 32'(first_oe_cyc - (k0 - 1)), 32'd5);
      check("r8_beats", 32'(cap_d1.size()), 32'd1);
      if (cap_d1.size() > 0) check("r8_d1", 32'(cap_d1[0]), 32'h00E4);
      if (cap_c1.size() > 0) check("r8_c1", 32'(cap_c1[0]), 32'd7);

      // READ32 with a slow core
      txn(C1_READ32, 15'd42, 4'd0, 16'h0, 16'h0, 1, 2, 32'hDEADBEEF, 1'b0, k0);
      check("r32_beats", 32'(cap_d1.size()), 32'd2);
      if (cap_d1.size() > 1) begin
         check("r32_lo", 32'(cap_d1[0]), 32'hBEEF);
         check("r32_hi", 32'(cap_d1[1]), 32'hDEAD);
      end

      // WRITE32 with the core stalling 4 cycles
      txn(C1_WRITE32, 15'd7, 4'd4, 16'h5678, 16'h1234, 4, 0, 32'h0, 1'b0, k0);
      check("w32_wdata", cap_wdata, 32'h12345678);
      check("w32_rv_cycles", 32'(cap_rv), 32'd5);

      // Reset while waiting on the core, then a stale completion
      clear_caps();
      @(negedge clk);
      c1_in = C1_READ16;
      a1_in = 15'd100;
      k0 = cyc + 1;
      exp_cmd = C1_READ16;
      exp_addr = {15'd100, 4'd2};
      exp_wdata = 32'h0;
      exp_rv[k0 + 1] = 1'b1;
      @(negedge clk);
      c1_in = C1_NOP;
      a1_in = 15'd2;
      @(negedge clk);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_req_cmd", 32'(req_cmd), 32'h0);
      m_reads = 0; m_writes = 0; m_inval = 0;
      reset = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = 32'h0BAD0BAD;
      @(negedge clk);
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      repeat (6) @(negedge clk);
      check("stale_no_drive", 32'(cap_c1.size()), 32'd0);

      // READ16 after the abort
      txn(C1_READ16, 15'd100, 4'd2, 16'h0, 16'h0, 0, 1, 32'hCAFE1234, 1'b0, k0);
      check("r16_beats", 32'(cap_d1.size()), 32'd1);
      if (cap_d1.size() > 0) check("r16_d1", 32'(cap_d1[0]), 32'h1234);

      // INVALIDATE_LINE with a spurious command during the core wait
      txn(C1_INVALIDATE_LINE, 15'h155, 4'd3, 16'hFFFF, 16'h0, 0, 2, 32'hFFFFFFFF, 1'b1, k0);
      check("inv_rv_cycles", 32'(cap_rv), 32'd1);
      check("inv_beats", 32'(cap_c1.size()), 32'd1);
      check("inv_d1_beats", 32'(cap_d1.size()), 32'd0);
      repeat (4) @(negedge clk);
      check("inv_no_extra", 32'(cap_c1.size()), 32'd1);

      // WRITE16 at the top of the address space
      txn(C1_WRITE16, 15'h7FFF, 4'hF, 16'hABCD, 16'h0, 0, 0, 32'h0, 1'b0, k0);
      check("w16_addr", 32'(cap_addr), 32'h7FFFF);
      check("w16_wdata", cap_wdata, 32'h0000ABCD);

`ifdef C1_RESP_STATS_EN
      check("stat_reads", stat_reads, 32'(m_reads));
      check("stat_writes", stat_writes, 32'(m_writes));
      check("stat_inval", stat_inval, 32'(m_inval));
      check("stat_inval_lit", stat_inval, 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
